// File: rtl/up_down_counter_if.sv
// Counter control/status bundle: enable and direction in, count value and flags out.
// Latency: none; this is a plain signal bundle.
// Backpressure: none; the counter accepts a control setting every cycle.
//
// Signals:
//   en      count enable (1 = count this cycle, 0 = hold)
//   up_dn   direction (1 = increment, 0 = decrement), used only when en=1
//   counter current registered count, N bits
//   at_max  high while counter == 2^N-1
//   at_min  high while counter == 0
//   wrap    one-cycle pulse in the cycle after a wrap-around transition
interface up_down_counter_if #(
  parameter int N = 16
);
  logic         en;
  logic         up_dn;
  logic [N-1:0] counter;
  logic         at_max;
  logic         at_min;
  logic         wrap;

  // The driver of en/up_dn (system logic or the bench).
  modport master (
    output en,
    output up_dn,
    input  counter,
    input  at_max,
    input  at_min,
    input  wrap
  );

  // The counter itself.
  modport slave (
    input  en,
    input  up_dn,
    output counter,
    output at_max,
    output at_min,
    output wrap
  );
endinterface

// File: rtl/up_down_counter.sv
// N-bit synchronous up/down counter with terminal-count flags and a wrap pulse.
// Latency: one clock from an enabling edge to the new count; flags decode the register.
// Backpressure: none; counts or holds every cycle as en/up_dn dictate.
//
// Ports:
//   clk  rising-edge clock
//   rst  synchronous reset, active-high; overrides en/up_dn
//   bus  up_down_counter_if.slave: en, up_dn in; counter, at_max, at_min, wrap out
module up_down_counter #(
  parameter int N = 16
) (
  input  logic                clk,
  input  logic                rst,
  up_down_counter_if.slave    bus
);

  localparam logic [N-1:0] ONE = N'(1);

  logic [N-1:0] count_q, count_d;
  logic         wrap_q,  wrap_d;

  // Terminal counts come straight from the register so they are clean
  // relative to clk and can be reused for the wrap decision below.
  logic is_max, is_min;
  assign is_max = &count_q;
  assign is_min = ~|count_q;

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (bus.en) begin
      if (bus.up_dn) begin
        count_d = count_q + ONE;
        wrap_d  = is_max;
      end else begin
        count_d = count_q - ONE;
        wrap_d  = is_min;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign bus.counter = count_q;
  assign bus.at_max  = is_max;
  assign bus.at_min  = is_min;
  assign bus.wrap    = wrap_q;

endmodule

// File: tb/tb_up_down_counter.sv
// Directed and random checks of up_down_counter (N=16).
// Inputs change 1 ns after each rising edge; outputs are sampled at that same point.
// Every comparison steps n_checks; every miss steps n_fail and prints a FAIL line.
module tb_up_down_counter;

  localparam int N = 16;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  up_down_counter_if #(.N(N)) bus ();

  up_down_counter #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one set of inputs across one rising edge, then settle past the edge.
  task automatic step(input logic r, input logic e, input logic u);
    rst       = r;
    bus.en    = e;
    bus.up_dn = u;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    n_checks++;
    if (bus.counter !== 16'd0) begin
      n_fail++; $display("FAIL reset_counter: got %0d expected 0", bus.counter);
    end
    n_checks++;
    if (bus.at_min !== 1'b1) begin
      n_fail++; $display("FAIL reset_at_min: got %b expected 1", bus.at_min);
    end
    n_checks++;
    if (bus.at_max !== 1'b0) begin
      n_fail++; $display("FAIL reset_at_max: got %b expected 0", bus.at_max);
    end
    n_checks++;
    if (bus.wrap !== 1'b0) begin
      n_fail++; $display("FAIL reset_wrap: got %b expected 0", bus.wrap);
    end
    step(1'b0, 1'b1, 1'b1);
    n_checks++;
    if (bus.counter !== 16'd1) begin
      n_fail++; $display("FAIL reset_release_first_up: got %0d expected 1", bus.counter);
    end
    n_checks++;
    if (bus.at_min !== 1'b0) begin
      n_fail++; $display("FAIL reset_release_at_min: got %b expected 0", bus.at_min);
    end
  endtask

  task automatic test_up_hold();
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1);
    n_checks++;
    if (bus.counter !== 16'd5) begin
      n_fail++; $display("FAIL up5_counter: got %0d expected 5", bus.counter);
    end
    // up_dn toggles during hold to show it is ignored when en=0.
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, i[0]);
      n_checks++;
      if (bus.counter !== 16'd5) begin
        n_fail++; $display("FAIL hold_counter cycle %0d: got %0d expected 5", i, bus.counter);
      end
      n_checks++;
      if (bus.wrap !== 1'b0) begin
        n_fail++; $display("FAIL hold_wrap cycle %0d: got %b expected 0", i, bus.wrap);
      end
    end
    for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 1'b0);
    n_checks++;
    if (bus.counter !== 16'd3) begin
      n_fail++; $display("FAIL down2_counter: got %0d expected 3", bus.counter);
    end
  endtask

  task automatic test_up_wrap();
    step(1'b1, 1'b0, 1'b0);
    // Six down steps from 0 reach 65530, leaving five up steps to the top.
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0);
    n_checks++;
    if (bus.counter !== 16'd65530) begin
      n_fail++; $display("FAIL near_top_counter: got %0d expected 65530", bus.counter);
    end
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1);
    n_checks++;
    if (bus.counter !== 16'd65535) begin
      n_fail++; $display("FAIL top_counter: got %0d expected 65535", bus.counter);
    end
    n_checks++;
    if (bus.at_max !== 1'b1) begin
      n_fail++; $display("FAIL top_at_max: got %b expected 1", bus.at_max);
    end
    n_checks++;
    if (bus.wrap !== 1'b0) begin
      n_fail++; $display("FAIL top_wrap: got %b expected 0", bus.wrap);
    end
    step(1'b0, 1'b1, 1'b1);
    n_checks++;
    if (bus.counter !== 16'd0) begin
      n_fail++; $display("FAIL up_wrap_counter: got %0d expected 0", bus.counter);
    end
    n_checks++;
    if (bus.wrap !== 1'b1) begin
      n_fail++; $display("FAIL up_wrap_pulse: got %b expected 1", bus.wrap);
    end
    n_checks++;
    if (bus.at_min !== 1'b1 || bus.at_max !== 1'b0) begin
      n_fail++; $display("FAIL up_wrap_flags: got min=%b max=%b expected min=1 max=0",
                         bus.at_min, bus.at_max);
    end
    step(1'b0, 1'b0, 1'b1);
    n_checks++;
    if (bus.wrap !== 1'b0) begin
      n_fail++; $display("FAIL up_wrap_pulse_width: got %b expected 0", bus.wrap);
    end
    n_checks++;
    if (bus.counter !== 16'd0) begin
      n_fail++; $display("FAIL up_wrap_hold_counter: got %0d expected 0", bus.counter);
    end
  endtask

  task automatic test_down_wrap();
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    n_checks++;
    if (bus.counter !== 16'd65535) begin
      n_fail++; $display("FAIL down_wrap_counter: got %0d expected 65535", bus.counter);
    end
    n_checks++;
    if (bus.wrap !== 1'b1) begin
      n_fail++; $display("FAIL down_wrap_pulse: got %b expected 1", bus.wrap);
    end
    n_checks++;
    if (bus.at_max !== 1'b1 || bus.at_min !== 1'b0) begin
      n_fail++; $display("FAIL down_wrap_flags: got max=%b min=%b expected max=1 min=0",
                         bus.at_max, bus.at_min);
    end
    step(1'b0, 1'b1, 1'b0);
    n_checks++;
    if (bus.counter !== 16'd65534) begin
      n_fail++; $display("FAIL down_after_wrap_counter: got %0d expected 65534", bus.counter);
    end
    n_checks++;
    if (bus.wrap !== 1'b0) begin
      n_fail++; $display("FAIL down_after_wrap_pulse: got %b expected 0", bus.wrap);
    end
    // Reset arriving on the same edge as a would-be wrap suppresses the pulse.
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    n_checks++;
    if (bus.wrap !== 1'b0 || bus.counter !== 16'd0) begin
      n_fail++; $display("FAIL reset_over_wrap: got cnt=%0d wrap=%b expected cnt=0 wrap=0",
                         bus.counter, bus.wrap);
    end
  endtask

  task automatic test_reset_mid();
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 100; i++) step(1'b0, 1'b1, 1'b1);
    n_checks++;
    if (bus.counter !== 16'd100) begin
      n_fail++; $display("FAIL mid_count_100: got %0d expected 100", bus.counter);
    end
    step(1'b1, 1'b1, 1'b1);
    n_checks++;
    if (bus.counter !== 16'd0) begin
      n_fail++; $display("FAIL mid_reset_counter: got %0d expected 0", bus.counter);
    end
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1);
    n_checks++;
    if (bus.counter !== 16'd3) begin
      n_fail++; $display("FAIL mid_resume_counter: got %0d expected 3", bus.counter);
    end
  endtask

  // Direction flips every edge, then two wraps on consecutive edges.
  task automatic test_back_to_back();
    logic [15:0] exp_cnt [6];
    logic        exp_wrp [6];
    logic        dir     [6];
    exp_cnt = '{16'd1, 16'd0, 16'd1, 16'd0, 16'd65535, 16'd0};
    exp_wrp = '{1'b0,  1'b0,  1'b0,  1'b0,  1'b1,      1'b1};
    dir     = '{1'b1,  1'b0,  1'b1,  1'b0,  1'b0,      1'b1};
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b1, dir[i]);
      n_checks++;
      if (bus.counter !== exp_cnt[i]) begin
        n_fail++; $display("FAIL b2b_counter step %0d: got %0d expected %0d",
                           i, bus.counter, exp_cnt[i]);
      end
      n_checks++;
      if (bus.wrap !== exp_wrp[i]) begin
        n_fail++; $display("FAIL b2b_wrap step %0d: got %b expected %b", i, bus.wrap, exp_wrp[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] m_cnt;
    logic        m_wrap;
    logic        r, e, u;
    step(1'b1, 1'b0, 1'b0);
    m_cnt  = 16'd0;
    m_wrap = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      r = ($urandom_range(0, 31) == 0);
      e = $urandom_range(0, 1);
      u = $urandom_range(0, 1);
      step(r, e, u);
      if (r) begin
        m_cnt  = 16'd0;
        m_wrap = 1'b0;
      end else if (e && u) begin
        m_wrap = (m_cnt == 16'hFFFF);
        m_cnt  = m_cnt + 16'd1;
      end else if (e) begin
        m_wrap = (m_cnt == 16'h0000);
        m_cnt  = m_cnt - 16'd1;
      end else begin
        m_wrap = 1'b0;
      end
      n_checks++;
      if (bus.counter !== m_cnt) begin
        n_fail++; $display("FAIL rand_counter cycle %0d: got %0d expected %0d", i, bus.counter, m_cnt);
      end
      n_checks++;
      if (bus.wrap !== m_wrap) begin
        n_fail++; $display("FAIL rand_wrap cycle %0d: got %b expected %b", i, bus.wrap, m_wrap);
      end
      n_checks++;
      if (bus.at_max !== (m_cnt == 16'hFFFF)) begin
        n_fail++; $display("FAIL rand_at_max cycle %0d: got %b expected %b",
                           i, bus.at_max, (m_cnt == 16'hFFFF));
      end
      n_checks++;
      if (bus.at_min !== (m_cnt == 16'h0000)) begin
        n_fail++; $display("FAIL rand_at_min cycle %0d: got %b expected %b",
                           i, bus.at_min, (m_cnt == 16'h0000));
      end
    end
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    bus.en    = 1'b0;
    bus.up_dn = 1'b0;
    #1;
    test_reset();
    test_up_hold();
    test_up_wrap();
    test_down_wrap();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
